mlp_layer_tdm: RTL and testbench
================================

MLP_LAYER_TDM -- requirements
Module: mlp_layer_tdm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point word width of inputs, weights, biases, outputs.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of every data word (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have parameters N_INPUTS, default 4, and N_NEURONS, default 4, each legal from 1 to 64.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, activation LUT address width, legal range 2 to DATA_WIDTH.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: in_valid  in  1  operand set valid; in_ready  out  1  operand set accepted when high with in_valid.
REQ-007 SHALL have port layer_inputs  in  DATA_WIDTH*N_INPUTS  input i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port layer_weights  in  DATA_WIDTH*N_INPUTS*N_NEURONS  weight (n,i) at [(n*N_INPUTS+i)*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port layer_biases  in  DATA_WIDTH*N_NEURONS  bias n at [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port act_mode  in  2  0 identity, 1 ReLU, 2 LUT, 3 treated as identity; sampled with operands.
REQ-011 SHALL have ports lut_we  in  1, lut_waddr  in  ADDR_WIDTH, lut_wdata  in  DATA_WIDTH: activation LUT write port.
REQ-012 SHALL have ports: layer_outputs  out  DATA_WIDTH*N_NEURONS  output n at [n*DATA_WIDTH +: DATA_WIDTH]; out_valid  out  1; out_ready  in  1.

Function
REQ-013 SHALL use one shared multiply-accumulate unit, time-multiplexed over all neurons and inputs.
REQ-014 SHALL implement states IDLE, MAC, ACT, DONE; in_ready SHALL be high only in IDLE.
REQ-015 IDLE: on in_valid&in_ready, SHALL register all operands and act_mode, set n=0, i=0, acc = bias0 sign-extended and left-shifted by FRAC_BITS, go MAC.
REQ-016 MAC: each cycle acc += x[i]*w[n][i] (full-precision signed, accumulator width 2*DATA_WIDTH+clog2(N_INPUTS)+1, no internal overflow); i==N_INPUTS-1 -> ACT, else i+1.
REQ-017 ACT: result = acc arithmetic-shifted right FRAC_BITS (floor), saturated to signed DATA_WIDTH range; activation applied; written to output n.
REQ-018 ReLU SHALL output 0 for negative results, result otherwise.
REQ-019 LUT mode SHALL output lut[a], a = {~result[DATA_WIDTH-1], result[DATA_WIDTH-2 -: ADDR_WIDTH-1]} (offset-binary top bits); LUT has 2^ADDR_WIDTH entries.
REQ-020 ACT with n<N_NEURONS-1 SHALL set n+1, i=0, acc = bias(n+1) aligned as REQ-015, go MAC; n==N_NEURONS-1 SHALL go DONE.
REQ-021 Latency: out_valid SHALL rise exactly N_NEURONS*(N_INPUTS+1) cycles after the accepting edge (20 at defaults).
REQ-022 DONE: out_valid high, layer_outputs stable; on out_ready high SHALL return to IDLE next cycle; out_ready low holds indefinitely.
REQ-023 Operand changes while not in IDLE SHALL have no effect on the computation in progress.
REQ-024 LUT writes SHALL be accepted in any state; a same-cycle write and ACT read of one address SHALL return the pre-write entry.
REQ-025 layer_outputs SHALL hold last completed values until overwritten neuron by neuron in the next computation.

Reset
REQ-026 rst high SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, layer_outputs=0, acc=0, n=0, i=0.
REQ-027 rst mid-computation SHALL abort it; no partial result SHALL be flagged valid.
REQ-028 LUT contents SHALL be cleared to 0 by reset.

Verification
REQ-029 Defaults, all inputs 0x0100, all weights 0x0100, biases 0, mode 0 -> every output 0x0400, out_valid at cycle 20 after accept.
REQ-030 Mode 1, inputs 0x0100, weights 0xFF00 (-1.0), bias 0x0080 -> every output 0x0000; mode 0 same operands -> 0xFC80.
REQ-031 Inputs 0x7FFF, weights 0x7FFF -> 0x7FFF; weights 0x8000 -> 0x8000 (saturation both ends).
REQ-032 Load lut[k]=k for all k, mode 2, result 0x0400 -> output 0x0084; result 0xFC00 -> 0x007C.
REQ-033 Hold out_ready low 10 cycles in DONE -> out_valid and outputs stable, in_ready low, new in_valid ignored; assert out_ready -> IDLE next cycle.
REQ-034 Assert rst at cycle 7 of a computation -> out_valid 0, outputs 0, in_ready 1 after release; next computation produces correct results.

Source files
------------

// File: rtl/mlp_layer_tdm.sv
`default_nettype none
// ============================================================================
// mlp_layer_tdm : fully-connected layer computed with one shared signed MAC
// Revision      : 1.0
// ============================================================================
module mlp_layer_tdm #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N_INPUTS   = 4,
    parameter int N_NEURONS  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH*N_INPUTS-1:0]           layer_inputs,
    input  logic [DATA_WIDTH*N_INPUTS*N_NEURONS-1:0] layer_weights,
    input  logic [DATA_WIDTH*N_NEURONS-1:0]          layer_biases,
    input  logic [1:0]                               act_mode,
    input  logic                                     lut_we,
    input  logic [ADDR_WIDTH-1:0]                    lut_waddr,
    input  logic [DATA_WIDTH-1:0]                    lut_wdata,
    output logic [DATA_WIDTH*N_NEURONS-1:0]          layer_outputs,
    output logic                                     out_valid,
    input  logic                                     out_ready
);

    localparam int ACC_W     = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1;
    localparam int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int IW        = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
    localparam int LUT_DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                               state_q, state_d;
    logic [NW-1:0]                            n_q, n_d;
    logic [IW-1:0]                            i_q, i_d;
    logic signed [ACC_W-1:0]                  acc_q, acc_d;
    logic [DATA_WIDTH*N_INPUTS-1:0]           x_q;
    logic [DATA_WIDTH*N_INPUTS*N_NEURONS-1:0] w_q;
    logic [DATA_WIDTH*N_NEURONS-1:0]          b_q;
    logic [1:0]                               mode_q;
    logic [DATA_WIDTH*N_NEURONS-1:0]          out_q;
    logic [DATA_WIDTH-1:0]                    lut_q [LUT_DEPTH];

    logic                           w_accept;
    logic signed [DATA_WIDTH-1:0]   w_x, w_w;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]        w_prod_ext;
    logic signed [DATA_WIDTH-1:0]   w_bias_raw;
    logic signed [ACC_W-1:0]        w_bias_ext;
    logic signed [ACC_W-1:0]        w_shifted;
    logic [DATA_WIDTH-1:0]          w_result;
    logic [ADDR_WIDTH-1:0]          w_lut_addr;
    logic [DATA_WIDTH-1:0]          w_act;

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign layer_outputs = out_q;
    assign w_accept      = in_valid && (state_q == S_IDLE);

    assign w_x        = x_q[int'(i_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_w        = w_q[(int'(n_q)*N_INPUTS + int'(i_q))*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod     = w_x * w_w;
    assign w_prod_ext = w_prod;

    // Bias for the neuron about to start: from the port at accept, else the captured copy.
    always_comb begin
        w_bias_raw = layer_biases[DATA_WIDTH-1:0];
        if (state_q == S_ACT && n_q != NW'(N_NEURONS-1))
            w_bias_raw = b_q[(int'(n_q)+1)*DATA_WIDTH +: DATA_WIDTH];
    end
    assign w_bias_ext = w_bias_raw;

    // Arithmetic shift floors toward minus infinity before saturation.
    assign w_shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        w_result = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX)
            w_result = SAT_MAX[DATA_WIDTH-1:0];
        else if (w_shifted < SAT_MIN)
            w_result = SAT_MIN[DATA_WIDTH-1:0];
    end

    assign w_lut_addr = {~w_result[DATA_WIDTH-1], w_result[DATA_WIDTH-2 -: ADDR_WIDTH-1]};

    always_comb begin
        w_act = w_result;
        case (mode_q)
            2'd1:    w_act = w_result[DATA_WIDTH-1] ? '0 : w_result;
            2'd2:    w_act = lut_q[w_lut_addr];
            default: w_act = w_result;
        endcase
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_MAC;
                    n_d     = '0;
                    i_d     = '0;
                    acc_d   = w_bias_ext <<< FRAC_BITS;
                end
            end
            S_MAC: begin
                acc_d = acc_q + w_prod_ext;
                if (i_q == IW'(N_INPUTS-1))
                    state_d = S_ACT;
                else
                    i_d = i_q + 1'b1;
            end
            S_ACT: begin
                if (n_q == NW'(N_NEURONS-1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MAC;
                    n_d     = n_q + 1'b1;
                    i_d     = '0;
                    acc_d   = w_bias_ext <<< FRAC_BITS;
                end
            end
            default: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            w_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
        end else if (w_accept) begin
            x_q    <= layer_inputs;
            w_q    <= layer_weights;
            b_q    <= layer_biases;
            mode_q <= act_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else if (state_q == S_ACT)
            out_q[int'(n_q)*DATA_WIDTH +: DATA_WIDTH] <= w_act;
    end

    // Reads in ACT see the old entry when a write to the same address lands this edge.
    generate
        for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    lut_q[g] <= '0;
                else if (lut_we && lut_waddr == ADDR_WIDTH'(g))
                    lut_q[g] <= lut_wdata;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_tdm.sv
`default_nettype none
// Directed self-checking bench for mlp_layer_tdm at default parameters.
module tb_mlp_layer_tdm;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  layer_inputs = '0;
    logic [255:0] layer_weights = '0;
    logic [63:0]  layer_biases = '0;
    logic [1:0]   act_mode = 2'd0;
    logic         lut_we = 1'b0;
    logic [7:0]   lut_waddr = '0;
    logic [15:0]  lut_wdata = '0;
    logic [63:0]  layer_outputs;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [63:0] snap;

    mlp_layer_tdm dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .layer_inputs(layer_inputs), .layer_weights(layer_weights),
        .layer_biases(layer_biases), .act_mode(act_mode),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .layer_outputs(layer_outputs), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [15:0] x, input logic [15:0] w,
                           input logic [15:0] b, input logic [1:0] m);
        for (int k = 0; k < 4; k++) layer_inputs[k*16 +: 16] = x;
        for (int k = 0; k < 16; k++) layer_weights[k*16 +: 16] = w;
        for (int k = 0; k < 4; k++) layer_biases[k*16 +: 16] = b;
        act_mode = m;
    endtask

    task automatic start_op;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        in_valid = 1'b0;
        layer_inputs  = {$urandom, $urandom};
        layer_weights = {8{$urandom}};
        layer_biases  = {$urandom, $urandom};
        act_mode      = 2'($urandom);
    endtask

    task automatic wait_done(input string tag);
        while (!out_valid && (cyc - t0) < 100) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(cyc - t0), 64'd20);
    endtask

    task automatic release_done;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ready_after_done", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] x, input logic [15:0] w,
                       input logic [15:0] b, input logic [1:0] m, input logic [15:0] e);
        set_ops(x, w, b, m);
        start_op();
        wait_done({tag, "_lat"});
        chk({tag, "_out"}, layer_outputs, {4{e}});
        release_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", layer_outputs, 64'd0);

        run("ident4", 16'h0100, 16'h0100, 16'h0000, 2'd0, 16'h0400);
        run("relu_neg", 16'h0100, 16'hFF00, 16'h0080, 2'd1, 16'h0000);
        run("ident_neg", 16'h0100, 16'hFF00, 16'h0080, 2'd0, 16'hFC80);
        run("mode3", 16'h0100, 16'hFF00, 16'h0080, 2'd3, 16'hFC80);
        run("relu_pos", 16'h0100, 16'h0100, 16'h0000, 2'd1, 16'h0400);
        run("sat_hi", 16'h7FFF, 16'h7FFF, 16'h0000, 2'd0, 16'h7FFF);
        run("sat_lo", 16'h7FFF, 16'h8000, 16'h0000, 2'd0, 16'h8000);
        run("floor", 16'h0001, 16'hFFFF, 16'h0000, 2'd0, 16'hFFFF);

        // Distinct neurons: out n = 4*(n+1) + n.
        set_ops(16'h0100, 16'h0000, 16'h0000, 2'd0);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) layer_weights[(n*4+i)*16 +: 16] = 16'((n+1) * 256);
            layer_biases[n*16 +: 16] = 16'(n * 256);
        end
        start_op();
        wait_done("distinct_lat");
        chk("distinct_out", layer_outputs, 64'h1300_0E00_0900_0400);
        release_done();

        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            lut_we = 1'b1;
            lut_waddr = 8'(k);
            lut_wdata = 16'(k);
        end
        @(negedge clk);
        lut_we = 1'b0;

        // Overwrite lut[0x84] on the edge where neuron 0 is activated.
        set_ops(16'h0100, 16'h0100, 16'h0000, 2'd2);
        start_op();
        repeat (4) @(posedge clk);
        #1;
        lut_we = 1'b1;
        lut_waddr = 8'h84;
        lut_wdata = 16'h1234;
        @(posedge clk);
        #1;
        lut_we = 1'b0;
        wait_done("lut_pos_lat");
        chk("lut_collide", layer_outputs, 64'h1234_1234_1234_0084);
        release_done();

        run("lut_neg", 16'h0100, 16'hFF00, 16'h0000, 2'd2, 16'h007C);

        set_ops(16'h0100, 16'h0100, 16'h0000, 2'd0);
        start_op();
        wait_done("hold_lat");
        snap = layer_outputs;
        set_ops(16'h7FFF, 16'h7FFF, 16'h0000, 2'd0);
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_outputs", layer_outputs, 64'h0400_0400_0400_0400);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        release_done();
        chk("after_release_valid", {63'd0, out_valid}, 64'd0);
        chk("after_release_outs", layer_outputs, snap);

        set_ops(16'h0100, 16'hFF00, 16'h0080, 2'd0);
        start_op();
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_outputs", layer_outputs, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_valid", {63'd0, out_valid}, 64'd0);

        run("lut_cleared", 16'h0100, 16'h0100, 16'h0000, 2'd2, 16'h0000);
        run("post_rst", 16'h0100, 16'h0100, 16'h0000, 2'd0, 16'h0400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
